// File: rtl/csi_rx_pkg.sv
// Shared CSI-2 receive definitions: sync pattern, aligner state encoding and
// bit-offset type, plus the window byte-extraction helper.
package csi_rx_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WIN_W  = 16;
  localparam int unsigned OFF_W  = 3;

  localparam logic [BYTE_W-1:0] CSI_SYNC_BYTE = 8'hB8;

  typedef enum logic {
    ALIGN_HUNT,
    ALIGN_LOCKED
  } align_state_t;

  typedef logic [OFF_W-1:0] bit_offset_t;

  // Byte starting at bit k of a two-word window (low word is the older one).
  function automatic logic [BYTE_W-1:0] window_byte(logic [WIN_W-1:0] w, bit_offset_t k);
    return BYTE_W'(w >> k);
  endfunction

endpackage

// File: rtl/csi_rx_sync_detect.sv
// Combinational sync search over a 16-bit window; reports the lowest matching
// bit offset so that ties resolve deterministically.
module csi_rx_sync_detect
  import csi_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = CSI_SYNC_BYTE
) (
  input  logic [15:0] window,
  output logic        hit_c,
  output logic [2:0]  offset_c
);

  // Scan from the top down so the lowest hit is the last one written.
  always_comb begin
    hit_c    = 1'b0;
    offset_c = '0;
    for (int k = 7; k >= 0; k--) begin
      if (window_byte(window, OFF_W'(k)) == SYNC_BYTE) begin
        hit_c    = 1'b1;
        offset_c = OFF_W'(k);
      end
    end
  end

endmodule

// File: rtl/csi_rx_byte_aligner.sv
// Per-lane HS byte aligner: hunts for the sync byte at any bit offset, locks to
// it and emits byte-aligned data until the packet handler ends the packet.
module csi_rx_byte_aligner
  import csi_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = CSI_SYNC_BYTE,
  parameter logic [7:0] HUNT_TIMEOUT = 8'd255
) (
  input  logic       byte_clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       wait_for_sync,
  input  logic       packet_done,
  input  logic [7:0] deser_in,
  output logic [7:0] aligned_byte,
  output logic       aligned_vld,
  output logic       locked,
  output logic [2:0] offset,
  output logic       hunt_timeout
);

  logic [BYTE_W-1:0] r0;
  logic [BYTE_W-1:0] r1;
  logic [BYTE_W-1:0] hunt_cnt;
  align_state_t      state;

  logic [WIN_W-1:0]  window_c;
  logic              sync_hit_c;
  logic [OFF_W-1:0]  sync_offset_c;
  logic [BYTE_W-1:0] locked_byte_c;
  logic              armed_c;

  assign window_c      = {r0, r1};
  assign locked_byte_c = window_byte(window_c, offset);
  assign armed_c       = enable && wait_for_sync;

  csi_rx_sync_detect #(
    .SYNC_BYTE (SYNC_BYTE)
  ) u_sync_detect (
    .window   (window_c),
    .hit_c    (sync_hit_c),
    .offset_c (sync_offset_c)
  );

  // Deserializer pipeline, hunt/lock FSM, timeout counter and output registers.
  always_ff @(posedge byte_clock) begin
    if (!reset_n) begin
      r0           <= '0;
      r1           <= '0;
      hunt_cnt     <= '0;
      state        <= ALIGN_HUNT;
      aligned_byte <= '0;
      aligned_vld  <= 1'b0;
      locked       <= 1'b0;
      offset       <= '0;
      hunt_timeout <= 1'b0;
    end else begin
      r0           <= deser_in;
      r1           <= r0;
      hunt_timeout <= 1'b0;
      case (state)
        ALIGN_HUNT: begin
          if (armed_c && sync_hit_c) begin
            state        <= ALIGN_LOCKED;
            locked       <= 1'b1;
            offset       <= sync_offset_c;
            aligned_byte <= SYNC_BYTE;
            aligned_vld  <= 1'b1;
            hunt_cnt     <= '0;
          end else begin
            aligned_vld <= 1'b0;
            if (!armed_c) begin
              hunt_cnt <= '0;
            end else if (hunt_cnt == HUNT_TIMEOUT) begin
              hunt_timeout <= 1'b1;
              hunt_cnt     <= '0;
            end else begin
              hunt_cnt <= hunt_cnt + 8'd1;
            end
          end
        end
        ALIGN_LOCKED: begin
          // The byte present in the terminating cycle is dropped.
          if (packet_done || !enable) begin
            state       <= ALIGN_HUNT;
            locked      <= 1'b0;
            aligned_vld <= 1'b0;
            hunt_cnt    <= '0;
          end else begin
            aligned_byte <= locked_byte_c;
            aligned_vld  <= 1'b1;
          end
        end
        default: begin
          state       <= ALIGN_HUNT;
          locked      <= 1'b0;
          aligned_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csi_rx_byte_aligner.sv
// Bench for csi_rx_byte_aligner: directed scenarios plus randomized traffic,
// all checked every cycle against a behavioural model of the aligner.
module tb_csi_rx_byte_aligner;

  localparam logic [7:0] SYNC = 8'hB8;
  localparam int HT = 4;

  logic       byte_clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       wait_for_sync = 1'b0;
  logic       packet_done = 1'b0;
  logic [7:0] deser_in = 8'h00;
  logic [7:0] aligned_byte;
  logic       aligned_vld;
  logic       locked;
  logic [2:0] offset;
  logic       hunt_timeout;

  logic [15:0] det_window = 16'h0000;
  logic        det_hit;
  logic [2:0]  det_off;

  always #5 byte_clock = ~byte_clock;

  csi_rx_byte_aligner #(
    .SYNC_BYTE    (SYNC),
    .HUNT_TIMEOUT (8'(HT))
  ) dut (
    .byte_clock    (byte_clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .wait_for_sync (wait_for_sync),
    .packet_done   (packet_done),
    .deser_in      (deser_in),
    .aligned_byte  (aligned_byte),
    .aligned_vld   (aligned_vld),
    .locked        (locked),
    .offset        (offset),
    .hunt_timeout  (hunt_timeout)
  );

  // Periodic pattern 0x49 can match at offsets 2 and 5 at once.
  csi_rx_sync_detect #(
    .SYNC_BYTE (8'h49)
  ) u_det (
    .window   (det_window),
    .hit_c    (det_hit),
    .offset_c (det_off)
  );

  int total = 0;
  int bad = 0;

  // Model: history of the last two words plus lock/offset/counter bookkeeping.
  logic [7:0] m_new = 8'h00;
  logic [7:0] m_old = 8'h00;
  bit         m_lk = 0;
  int         m_off = 0;
  int         m_cnt = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_vld = 0;
  bit         m_tmo = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find_sync(input int w);
    for (int k = 0; k < 8; k++)
      if (((w >> k) & 255) == int'(SYNC)) return k;
    return -1;
  endfunction

  task automatic model_edge(input logic [7:0] d, input bit en, input bit wfs,
                            input bit pd, input bit rn);
    int w;
    int k;
    if (!rn) begin
      m_new = 0; m_old = 0; m_lk = 0; m_off = 0; m_cnt = 0;
      m_byte = 0; m_vld = 0; m_tmo = 0;
      return;
    end
    w = int'(m_new) * 256 + int'(m_old);
    k = find_sync(w);
    m_tmo = 0;
    if (!m_lk) begin
      if (en && wfs && k >= 0) begin
        m_lk = 1; m_off = k; m_byte = SYNC; m_vld = 1; m_cnt = 0;
      end else begin
        m_vld = 0;
        if (!(en && wfs)) m_cnt = 0;
        else if (m_cnt == HT) begin m_tmo = 1; m_cnt = 0; end
        else m_cnt = m_cnt + 1;
      end
    end else if (pd || !en) begin
      m_lk = 0; m_vld = 0; m_cnt = 0;
    end else begin
      m_byte = 8'((w >> m_off) & 255);
      m_vld = 1;
    end
    m_old = m_new;
    m_new = d;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after.
  task automatic step(input logic [7:0] d, input bit en, input bit wfs,
                      input bit pd, input bit rn);
    deser_in = d; enable = en; wait_for_sync = wfs; packet_done = pd; reset_n = rn;
    @(posedge byte_clock);
    model_edge(d, en, wfs, pd, rn);
    #1;
    chk("aligned_vld", aligned_vld, m_vld);
    chk("locked", locked, m_lk);
    chk("offset", offset, m_off);
    chk("hunt_timeout", hunt_timeout, m_tmo);
    chk("aligned_byte", aligned_byte, m_byte);
  endtask

  task automatic feed(input logic [7:0] d);
    step(d, 1, 1, 0, 1);
  endtask

  logic [7:0] pend[$];

  initial begin
    step(8'h00, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0);
    chk("rst_vld", aligned_vld, 0);
    chk("rst_locked", locked, 0);
    chk("rst_byte", aligned_byte, 0);
    chk("rst_offset", offset, 0);

    // Offset 3 lock: window 0x05C0.
    feed(8'h00); feed(8'hC0); feed(8'h05); feed(8'h2A);
    chk("off3_offset", offset, 3);
    chk("off3_first", aligned_byte, 8'hB8);
    chk("off3_locked", locked, 1);
    feed(8'h11);
    chk("off3_next", aligned_byte, 8'h40);
    step(8'h00, 1, 1, 1, 1);
    chk("pd_vld", aligned_vld, 0);
    chk("pd_locked", locked, 0);

    // Offset 0: window 0xB8B8.
    feed(8'hB8); feed(8'hB8); feed(8'h00);
    chk("off0_offset", offset, 0);
    chk("off0_first", aligned_byte, 8'hB8);
    step(8'h00, 1, 1, 1, 1);

    // No lock while the packet handler is not waiting.
    step(8'h00, 1, 0, 0, 1); step(8'h2E, 1, 0, 0, 1);
    step(8'h00, 1, 0, 0, 1); step(8'h00, 1, 0, 0, 1);
    chk("gated_locked", locked, 0);
    chk("gated_vld", aligned_vld, 0);

    // Relock at offset 6: window 0x2E00.
    feed(8'h00); feed(8'h2E); feed(8'h00);
    chk("off6_offset", offset, 6);
    chk("off6_locked", locked, 1);

    // Reset while locked.
    step(8'h55, 1, 1, 0, 0);
    chk("mid_rst_vld", aligned_vld, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_offset", offset, 0);
    chk("mid_rst_byte", aligned_byte, 0);

    // Enable drop while locked.
    feed(8'h00); feed(8'h2E); feed(8'h00);
    chk("relock_locked", locked, 1);
    step(8'h77, 0, 1, 0, 1);
    chk("en_low_vld", aligned_vld, 0);
    chk("en_low_locked", locked, 0);

    // Timeout period with HUNT_TIMEOUT = 4.
    step(8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      feed(8'h00);
      chk("tmo_period", hunt_timeout, (i % 5 == 4) ? 1 : 0);
      chk("tmo_hunt", locked, 0);
    end

    // Priority among simultaneous hits.
    det_window = 16'h0924;
    #1;
    chk("multi_hit", det_hit, 1);
    chk("multi_off", det_off, 2);
    det_window = 16'h0000;
    #1;
    chk("no_hit", det_hit, 0);

    // Randomized traffic with injected sync words.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] d;
      if (pend.size() == 0 && $urandom_range(9) == 0) begin
        logic [15:0] v;
        v = 16'(SYNC) << $urandom_range(7);
        v = v | 16'($urandom_range(255) & ((1 << 0) - 1));
        pend.push_back(v[7:0]);
        pend.push_back(v[15:8]);
      end
      d = (pend.size() != 0) ? pend.pop_front() : 8'($urandom_range(255));
      step(d, $urandom_range(19) != 0, $urandom_range(4) != 0,
           $urandom_range(29) == 0, $urandom_range(299) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
